// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (read-only) and the LSU (read/write).
// The memory read latency is fixed. A fairness counter stops a busy LSU from starving fetch.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT  = 2,
    parameter int unsigned FAIR_MAX = 2,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] { IDLE, ACCESS, WAIT, RESP } state_t;

    state_t           state;
    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] fair_cnt;
    logic             win_lsu;
    logic             acc_we;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    // Winner selection: the LSU wins ties until it has taken FAIR_MAX grants in a row past a waiting fetch.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst && state == IDLE) begin
            if (d_req && !(if_req && fair_cnt == CNT_W'(FAIR_MAX)))
                d_gnt = 1'b1;
            else if (if_req)
                if_gnt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            fair_cnt  <= '0;
            win_lsu   <= 1'b0;
            acc_we    <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_gnt) begin
                        state     <= ACCESS;
                        busy      <= 1'b1;
                        win_lsu   <= 1'b1;
                        acc_we    <= d_we;
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_be    <= d_we ? d_be : 4'hF;
                        mem_addr  <= d_addr[ADDR_W+1:2];
                        mem_wdata <= d_wdata;
                        if (!if_req)
                            fair_cnt <= '0;
                        else if (fair_cnt != CNT_W'(FAIR_MAX))
                            fair_cnt <= fair_cnt + CNT_W'(1);
                    end else if (if_gnt) begin
                        state    <= ACCESS;
                        busy     <= 1'b1;
                        win_lsu  <= 1'b0;
                        acc_we   <= 1'b0;
                        mem_en   <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_be   <= 4'hF;
                        mem_addr <= if_addr[ADDR_W+1:2];
                        fair_cnt <= '0;
                    end
                end
                ACCESS: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    lat_cnt <= CNT_W'(MEM_LAT - 1);
                    state   <= WAIT;
                end
                WAIT: begin
                    // lat_cnt reaches zero in the cycle the memory presents read data.
                    if (lat_cnt == '0) begin
                        state <= RESP;
                        if (win_lsu) begin
                            d_rvalid <= 1'b1;
                            if (!acc_we)
                                d_rdata <= mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic checked against a cycle-level model.
// Instance a uses MEM_LAT=2, instance b uses MEM_LAT=1. Both use FAIR_MAX=2.
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned MEM_LAT  = 2;
    localparam int unsigned FAIR_MAX = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              if_req, if_gnt, if_rvalid;
    logic [31:0]       if_addr, if_rdata;
    logic              d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]        d_be;
    logic [31:0]       d_addr, d_wdata, d_rdata;
    logic              mem_en, mem_we, busy;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    logic              b_if_req, b_if_gnt, b_if_rvalid;
    logic [31:0]       b_if_addr, b_if_rdata;
    logic              b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic [3:0]        b_d_be;
    logic [31:0]       b_d_addr, b_d_wdata, b_d_rdata;
    logic              b_mem_en, b_mem_we, b_busy;
    logic [3:0]        b_mem_be;
    logic [ADDR_W-1:0] b_mem_addr;
    logic [31:0]       b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .FAIR_MAX(FAIR_MAX), .ADDR_W(ADDR_W)) dut_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LAT(1), .FAIR_MAX(FAIR_MAX), .ADDR_W(ADDR_W)) dut_b (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_d_rdata  = '0;

    logic [31:0] mem_a   [1024];
    logic [31:0] ref_mem [1024];

    function automatic logic [31:0] pat(input int unsigned a);
        return 32'hA5C3_0000 ^ (a * 32'h0001_0101) ^ 32'(a << 3);
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i]   = pat(i);
            ref_mem[i] = pat(i);
        end
        mem_a[4]   = 32'h0050_0093;
        ref_mem[4] = 32'h0050_0093;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory behind instance a: data is valid only in the cycle MEM_LAT after mem_en.
    int a_acc = -100;
    logic [ADDR_W-1:0] a_acc_addr = '0;
    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            a_acc      = cyc;
            a_acc_addr = mem_addr;
            if (mem_we === 1'b1)
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) mem_a[mem_addr][8*i +: 8] = mem_wdata[8*i +: 8];
        end
        mem_rdata = (cyc == a_acc + int'(MEM_LAT)) ? mem_a[a_acc_addr] : (32'hBAD0_0000 ^ 32'(cyc));
    end

    // Read-only memory behind instance b, which has a one-cycle latency.
    int b_acc = -100;
    logic [ADDR_W-1:0] b_acc_addr = '0;
    always @(negedge clk) begin
        if (b_mem_en === 1'b1) begin
            b_acc      = cyc;
            b_acc_addr = b_mem_addr;
        end
        b_mem_rdata = (cyc == b_acc + 1) ? pat(32'(b_acc_addr)) : (32'hBAD1_0000 ^ 32'(cyc));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        bit late;
        late = 1'b0;
        rst = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy} !== 7'b0 || if_rdata !== 32'h0 ||
            d_rdata !== 32'h0 || mem_addr !== '0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b%b rv=%b%b en=%b we=%b busy=%b addr=%h be=%h, required all 0",
                     if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy, mem_addr, mem_be);
        end
        d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        d_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (d_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_load_gnt: d_gnt=%b required 1", d_gnt);
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy} !== 7'b0 || mem_addr !== '0 ||
            d_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_access: en=%b busy=%b rv=%b addr=%h, required all 0",
                     mem_en, busy, d_rvalid, mem_addr);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (d_rvalid !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0) late = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (late) begin
            n_fail++;
            $display("FAIL reset_abandon: activity seen after reset release, required idle");
        end
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1; if_addr = 32'h0000_0010;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            n_checks++;
            case (k)
                0: if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin
                    n_fail++; $display("FAIL fetch_gnt: if_gnt=%b d_gnt=%b required 1 0", if_gnt, d_gnt);
                end
                1: if (mem_en !== 1'b1 || mem_addr !== 10'd4 || mem_we !== 1'b0 || mem_be !== 4'hF) begin
                    n_fail++;
                    $display("FAIL fetch_port: en=%b addr=%h we=%b be=%h required 1 004 0 f", mem_en, mem_addr, mem_we, mem_be);
                end
                2, 3: if (mem_en !== 1'b0 || if_rvalid !== 1'b0 || busy !== 1'b1) begin
                    n_fail++; $display("FAIL fetch_wait: en=%b rv=%b busy=%b required 0 0 1", mem_en, if_rvalid, busy);
                end
                4: if (if_rvalid !== 1'b1 || if_rdata !== 32'h0050_0093 || d_rvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fetch_resp: rv=%b data=%h drv=%b required 1 00500093 0", if_rvalid, if_rdata, d_rvalid);
                end
                default: if (busy !== 1'b0 || if_rvalid !== 1'b0) begin
                    n_fail++; $display("FAIL fetch_done: busy=%b rv=%b required 0 0", busy, if_rvalid);
                end
            endcase
            @(posedge clk); #1;
            if (k == 0) if_req = 1'b0;
        end
        exp_if_rdata = 32'h0050_0093;
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
        ref_mem[8][15:0] = 16'hBEEF;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            n_checks++;
            case (k)
                0: if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
                    n_fail++; $display("FAIL store_gnt: d_gnt=%b if_gnt=%b required 1 0", d_gnt, if_gnt);
                end
                1: if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_addr !== 10'd8 ||
                       mem_wdata !== 32'hDEAD_BEEF) begin
                    n_fail++;
                    $display("FAIL store_port: en=%b we=%b be=%h addr=%h wd=%h required 1 1 3 008 deadbeef",
                             mem_en, mem_we, mem_be, mem_addr, mem_wdata);
                end
                2, 3: if (mem_we !== 1'b0 || d_rvalid !== 1'b0) begin
                    n_fail++; $display("FAIL store_wait: we=%b rv=%b required 0 0", mem_we, d_rvalid);
                end
                4: if (d_rvalid !== 1'b1 || d_rdata !== exp_d_rdata || if_rvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL store_ack: rv=%b rdata=%h irv=%b required 1 %h 0", d_rvalid, d_rdata, if_rvalid, exp_d_rdata);
                end
                default: if (mem_a[8] !== ref_mem[8]) begin
                    n_fail++; $display("FAIL store_mem: word=%h required %h", mem_a[8], ref_mem[8]);
                end
            endcase
            @(posedge clk); #1;
            if (k == 0) begin d_req = 1'b0; d_we = 1'b0; end
        end
    endtask

    task automatic test_fairness();
        int g_cyc [6];
        bit g_lsu [6];
        int ng;
        int overlap;
        logic [5:0] exp_order;
        ng = 0; overlap = 0;
        exp_order = 6'b011011;
        if_req = 1'b1; if_addr = 32'h0000_0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0184;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            @(negedge clk);
            if (if_gnt === 1'b1 && d_gnt === 1'b1) overlap++;
            else if (if_gnt === 1'b1 || d_gnt === 1'b1) begin
                g_cyc[ng] = c; g_lsu[ng] = d_gnt; ng++;
            end
            @(posedge clk); #1;
        end
        if_req = 1'b0; d_req = 1'b0;
        n_checks++;
        if (ng != 6 || overlap != 0) begin
            n_fail++; $display("FAIL fair_count: grants=%0d overlaps=%0d required 6 0", ng, overlap);
        end
        for (int i = 0; i < ng; i++) begin
            n_checks++;
            if (g_lsu[i] !== exp_order[i]) begin
                n_fail++; $display("FAIL fair_order: grant %0d lsu=%b required %b", i, g_lsu[i], exp_order[i]);
            end
            if (i > 0) begin
                n_checks++;
                if (g_cyc[i] - g_cyc[i-1] != int'(MEM_LAT) + 3) begin
                    n_fail++; $display("FAIL fair_spacing: grant %0d gap=%0d required %0d", i, g_cyc[i] - g_cyc[i-1], MEM_LAT + 3);
                end
            end
        end
        repeat (8) @(posedge clk);
        #1;
        exp_if_rdata = ref_mem[10'h40];
        exp_d_rdata  = ref_mem[10'h61];
    endtask

    task automatic test_lsu_alone();
        bit g_lsu [7];
        int ng;
        logic [6:0] exp_order;
        ng = 0;
        exp_order = 7'b0111111;
        if_req = 1'b0; if_addr = 32'h0000_030C;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0208;
        for (int c = 0; c < 100 && ng < 7; c++) begin
            @(negedge clk);
            if (if_gnt === 1'b1 || d_gnt === 1'b1) begin
                g_lsu[ng] = d_gnt; ng++;
            end
            @(posedge clk); #1;
            if (ng >= 4) if_req = 1'b1;
        end
        if_req = 1'b0; d_req = 1'b0;
        n_checks++;
        if (ng != 7) begin
            n_fail++; $display("FAIL lsu_alone_count: grants=%0d required 7", ng);
        end
        for (int i = 0; i < ng; i++) begin
            n_checks++;
            if (g_lsu[i] !== exp_order[i]) begin
                n_fail++; $display("FAIL lsu_alone_order: grant %0d lsu=%b required %b", i, g_lsu[i], exp_order[i]);
            end
        end
        repeat (8) @(posedge clk);
        #1;
        exp_if_rdata = ref_mem[10'hC3];
        exp_d_rdata  = ref_mem[10'h82];
    endtask

    task automatic test_random();
        int next_free, last_g, resp_c, streak;
        bit resp_lsu, resp_st, e_ig, e_dg, g_i, g_d;
        logic [31:0] resp_data, acc_wdata;
        logic [ADDR_W-1:0] acc_addr;
        logic [3:0] acc_be;
        bit acc_we;
        next_free = 0; last_g = -100; resp_c = -100; streak = 0;
        resp_lsu = 1'b0; resp_st = 1'b0; resp_data = '0;
        acc_addr = '0; acc_be = '0; acc_we = 1'b0; acc_wdata = '0;
        if_req = 1'b0; d_req = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            g_i = (if_gnt === 1'b1);
            g_d = (d_gnt === 1'b1);
            e_ig = 1'b0; e_dg = 1'b0;
            if (c >= next_free && (if_req || d_req)) begin
                if (d_req && !(if_req && streak == int'(FAIR_MAX))) e_dg = 1'b1;
                else e_ig = 1'b1;
            end
            n_checks++;
            if ({if_gnt, d_gnt} !== {e_ig, e_dg}) begin
                n_fail++; $display("FAIL rnd_gnt: c=%0d gnt if/d=%b%b required %b%b", c, if_gnt, d_gnt, e_ig, e_dg);
            end
            n_checks++;
            if (busy !== (c > last_g && c < next_free) || mem_en !== (c == last_g + 1)) begin
                n_fail++; $display("FAIL rnd_busy_en: c=%0d busy=%b en=%b last_grant=%0d", c, busy, mem_en, last_g);
            end
            if (c == last_g + 1) begin
                n_checks++;
                if ({mem_we, mem_be, mem_addr} !== {acc_we, (acc_we ? acc_be : 4'hF), acc_addr} ||
                    (acc_we && mem_wdata !== acc_wdata)) begin
                    n_fail++;
                    $display("FAIL rnd_port: c=%0d we=%b be=%h addr=%h wd=%h required %b %h %h %h",
                             c, mem_we, mem_be, mem_addr, mem_wdata, acc_we, (acc_we ? acc_be : 4'hF), acc_addr, acc_wdata);
                end
            end
            n_checks++;
            if ({if_rvalid, d_rvalid} !== {(c == resp_c && !resp_lsu), (c == resp_c && resp_lsu)}) begin
                n_fail++; $display("FAIL rnd_rvalid: c=%0d rv if/d=%b%b resp_cycle=%0d lsu=%b", c, if_rvalid, d_rvalid, resp_c, resp_lsu);
            end
            if (c == resp_c && !resp_st) begin
                if (resp_lsu) exp_d_rdata = resp_data;
                else exp_if_rdata = resp_data;
            end
            n_checks++;
            if (if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin
                n_fail++;
                $display("FAIL rnd_rdata: c=%0d if=%h d=%h required %h %h", c, if_rdata, d_rdata, exp_if_rdata, exp_d_rdata);
            end
            if (e_ig || e_dg) begin
                last_g = c; next_free = c + int'(MEM_LAT) + 3; resp_c = c + int'(MEM_LAT) + 2; resp_lsu = e_dg;
                if (e_dg) begin
                    acc_addr = d_addr[ADDR_W+1:2]; acc_we = d_we; acc_be = d_be; acc_wdata = d_wdata;
                    streak = !if_req ? 0 : (streak < int'(FAIR_MAX) ? streak + 1 : streak);
                end else begin
                    acc_addr = if_addr[ADDR_W+1:2]; acc_we = 1'b0; acc_be = 4'hF;
                    streak = 0;
                end
                resp_st = acc_we;
                if (acc_we) begin
                    for (int i = 0; i < 4; i++)
                        if (acc_be[i]) ref_mem[acc_addr][8*i +: 8] = acc_wdata[8*i +: 8];
                end else begin
                    resp_data = ref_mem[acc_addr];
                end
            end
            @(posedge clk); #1;
            if (g_d || (d_req && $urandom_range(0, 19) == 0)) d_req = 1'b0;
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom); d_wdata = $urandom;
                d_addr = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 31)) << 2);
            end
            if (g_i || (if_req && $urandom_range(0, 19) == 0)) if_req = 1'b0;
            if (!if_req && $urandom_range(0, 2) != 0) begin
                if_req = 1'b1;
                if_addr = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 31)) << 2);
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_lat1();
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h0000_0044;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            n_checks++;
            case (k)
                0: if (b_d_gnt !== 1'b1 || b_if_gnt !== 1'b0) begin
                    n_fail++; $display("FAIL lat1_gnt: d_gnt=%b if_gnt=%b required 1 0", b_d_gnt, b_if_gnt);
                end
                1: if (b_mem_en !== 1'b1 || b_mem_addr !== 10'h11 || b_mem_we !== 1'b0 || b_mem_be !== 4'hF ||
                       b_mem_wdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL lat1_port: en=%b addr=%h we=%b be=%h wd=%h required 1 011 0 f 0",
                             b_mem_en, b_mem_addr, b_mem_we, b_mem_be, b_mem_wdata);
                end
                2: if (b_mem_en !== 1'b0 || b_d_rvalid !== 1'b0) begin
                    n_fail++; $display("FAIL lat1_wait: en=%b rv=%b required 0 0", b_mem_en, b_d_rvalid);
                end
                3: if (b_d_rvalid !== 1'b1 || b_d_rdata !== pat(32'h11) || b_if_rvalid !== 1'b0 || b_if_rdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL lat1_resp: rv=%b data=%h irv=%b required 1 %h 0", b_d_rvalid, b_d_rdata, b_if_rvalid, pat(32'h11));
                end
                default: if (b_busy !== 1'b0 || b_d_rvalid !== 1'b0) begin
                    n_fail++; $display("FAIL lat1_done: busy=%b rv=%b required 0 0", b_busy, b_d_rvalid);
                end
            endcase
            @(posedge clk); #1;
            if (k == 0) b_d_req = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        b_if_req = 1'b0; b_if_addr = '0;
        b_d_req = 1'b0; b_d_we = 1'b0; b_d_be = '0; b_d_addr = '0; b_d_wdata = '0;
        test_reset();
        test_single_fetch();
        test_store();
        test_fairness();
        test_lsu_alone();
        test_random();
        test_lat1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified instruction/data memory between the RV32I core's instruction-fetch stage (IF, read-only) and load/store unit (LSU, read/write). Arbitrates requests and drives the memory port. Counts a fixed memory read latency, then returns data and a one-cycle valid to the winning requester. Sits between the RISC_V core's fetch/LSU and the memory macro.

Parameters:
MEM_LAT, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid (legal range 1..15)
FAIR_MAX, 2, max consecutive LSU grants while IF is waiting before IF is forced to win (1..15)
ADDR_W, 10, word-address width of the memory port

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  32  fetch byte address
if_gnt  out  1  fetch request accepted (combinational, this cycle)
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  32  fetched instruction
d_req  in  1  LSU request; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_be  in  4  store byte enables
d_addr  in  32  LSU byte address
d_wdata  in  32  store data
d_gnt  out  1  LSU request accepted (combinational)
d_rvalid  out  1  one-cycle pulse: load data valid, or store acknowledged
d_rdata  out  32  load data
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable
mem_be  out  4  memory byte enables (4'b1111 for reads)
mem_addr  out  ADDR_W  word address = byte addr[ADDR_W+1:2]
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; fair_cnt=0. All outputs, including if_rdata/d_rdata, go to 0. An in-flight access is abandoned and produces no rvalid.
- FSM states are IDLE, ACCESS, WAIT, RESP. Requests are accepted only in IDLE.
- IDLE, cycle T, with at least one req:
  - Pick the winner and assert its gnt combinationally in T.
  - Latch addr/we/be/wdata and the winner id at the end of T.
  - Go to ACCESS.
- Winner selection:
  - Only one req high: that requester wins.
  - Both high: LSU wins unless fair_cnt==FAIR_MAX, in which case IF wins.
- fair_cnt update:
  - +1 on an LSU grant while if_req=1, saturating at FAIR_MAX.
  - Cleared on any IF grant, and on an LSU grant with if_req=0.
- ACCESS (T+1):
  - mem_en=1 for exactly this cycle; mem_we/mem_be/mem_addr/mem_wdata from the latched regs.
  - Reads drive mem_be=4'b1111 and mem_we=0.
  - Load lat_cnt=MEM_LAT-1 and go to WAIT, or go straight to RESP capture if MEM_LAT==1.
- WAIT: decrement lat_cnt each cycle. In cycle T+1+MEM_LAT, capture mem_rdata into the winner's rdata register and go to RESP.
- RESP (T+2+MEM_LAT):
  - The winner's rvalid=1 for one cycle; next state IDLE.
  - Stores pulse d_rvalid but leave d_rdata unchanged.
  - rdata registers hold their value until the next capture for the same requester.
- Access latency is T to rvalid = MEM_LAT+2 cycles. Minimum spacing between grants is MEM_LAT+3 cycles.
- Outside ACCESS: mem_en=0, mem_we=0. mem_addr/mem_be/mem_wdata hold the last latched values.
- A req dropped before its gnt is simply ignored. A req held through RESP is granted in the following IDLE cycle.
- gnt is never asserted outside IDLE. if_gnt and d_gnt are never high together. if_rvalid and d_rvalid are never high together.
- Address bits [1:0] and bits above ADDR_W+1 are ignored; misalignment is not checked.

Test Plan:
- Reset mid-access: grant a load at T, drop rst at T+2 → all outputs 0, no d_rvalid ever appears. After release, state IDLE and busy=0.
- Single fetch, MEM_LAT=2: if_req, if_addr=0x0000_0010 at T → if_gnt at T, mem_en with mem_addr=4 at T+1. mem_rdata=0x0050_0093 at T+3 → if_rvalid with if_rdata=0x0050_0093 at T+4, busy low at T+5.
- Store: d_req, d_we=1, d_be=4'b0011, d_addr=0x20, d_wdata=0xDEAD_BEEF → mem_en, mem_we=1, mem_be=4'b0011, mem_addr=8, mem_wdata=0xDEAD_BEEF at T+1. d_rvalid at T+4 with d_rdata unchanged; if_rvalid stays 0.
- Simultaneous requests, FAIR_MAX=2, both reqs held continuously:
  - Grant order must be LSU, LSU, IF, LSU, LSU, IF.
  - Grants spaced 5 cycles apart; gnt signals never overlap.
- LSU alone: d_req held, if_req=0 → every grant goes to LSU and fair_cnt stays 0. Raising if_req then wins only after 2 further LSU grants.
- MEM_LAT=1 build: single load → d_rvalid exactly 3 cycles after d_gnt, with mem_rdata sampled in the cycle after mem_en.
